// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: sizes, FSM encoding,
// requester identities and the fixed table base addresses in memory.
package mem_arb_pkg;

    localparam int MEM_DEPTH  = 1024;
    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;
    localparam int NUM_REQ    = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        TAIL = 3'd3,
        DONE = 3'd4
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_REWARD   = 2'd0;
    localparam req_id_t REQ_LEARNING = 2'd1;
    localparam req_id_t REQ_ROUTING  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ACTION_BASE  = 16'h0048;
    localparam logic [ADDR_WIDTH-1:0] BATTERY_BASE = 16'h0148;
    localparam logic [ADDR_WIDTH-1:0] QVALUE_BASE  = 16'h01C8;

    // Successor in the fixed 0 -> 1 -> 2 -> 0 rotation.
    function automatic req_id_t next_id(input req_id_t id);
        return (id == REQ_ROUTING) ? REQ_REWARD : req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester bus plus byte-memory port of the arbiter. The slave modport is
// the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*WORD_WIDTH-1:0] addr_in;
    logic [NUM_REQ*WORD_WIDTH-1:0] wdata_in;
    logic [NUM_REQ-1:0]            ack;
    logic [WORD_WIDTH-1:0]         rdata;
    logic                          err;

    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_we;
    logic [BYTE_WIDTH-1:0]         mem_wdata;
    logic [BYTE_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  req, we, addr_in, wdata_in, mem_rdata,
        output ack, rdata, err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, we, addr_in, wdata_in, mem_rdata,
        input  ack, rdata, err, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin requester selection: search starts one past the last grant.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            last_grant,
    output req_id_t            grant,
    output logic               valid
);

    req_id_t cand0;
    req_id_t cand1;
    req_id_t cand2;

    always_comb begin
        cand0 = next_id(last_grant);
        cand1 = next_id(cand0);
        cand2 = next_id(cand1);
        grant = cand0;
        valid = 1'b1;
        if (req[cand0]) begin
            grant = cand0;
        end else if (req[cand1]) begin
            grant = cand1;
        end else if (req[cand2]) begin
            grant = cand2;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter onto a byte-wide memory; each 16-bit access is two
// byte cycles (high byte first). Define MEM_BOUNDS_CHECK_EN to reject
// addresses past MEM_DEPTH-2 with err instead of wrapping.
module mem_port_arbiter #(
    parameter int MEM_DEPTH  = mem_arb_pkg::MEM_DEPTH,
    parameter int WORD_WIDTH = mem_arb_pkg::WORD_WIDTH
) (
    input logic               clock,
    input logic               nreset,
    mem_port_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    arb_state_t state;
    arb_state_t state_nxt;

    req_id_t grant_q;
    req_id_t last_grant_q;
    req_id_t pick_id;
    logic    pick_vld;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [BYTE_WIDTH-1:0] rd_hi_q;
    logic [WORD_WIDTH-1:0] rdata_q;

    logic [NUM_REQ-1:0][WORD_WIDTH-1:0] addr_vec;
    logic [NUM_REQ-1:0][WORD_WIDTH-1:0] wdata_vec;

    assign addr_vec  = bus.addr_in;
    assign wdata_vec = bus.wdata_in;

    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH:0] a);
        return ADDR_WIDTH'(32'(a) % 32'(MEM_DEPTH));
    endfunction

    rr_pick u_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .grant      (pick_id),
        .valid      (pick_vld)
    );

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob;
    logic err_q;

    // The second byte lives at addr+1, so the last legal word address is DEPTH-2.
    assign oob     = 32'(addr_vec[pick_id]) > 32'(MEM_DEPTH - 2);
    assign bus.err = err_q & (state == DONE);
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata = rdata_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            grant_q      <= REQ_REWARD;
            last_grant_q <= REQ_ROUTING;
            rdata_q      <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick_id;
`ifdef MEM_BOUNDS_CHECK_EN
                        err_q <= oob;
                        if (oob) begin
                            rdata_q <= '0;
                        end
`endif
                    end
                end
                // rdata changes only here so it stays stable outside DONE.
                TAIL:    rdata_q      <= {rd_hi_q, bus.mem_rdata};
                DONE:    last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && pick_vld) begin
            we_q    <= bus.we[pick_id];
            addr_q  <= addr_vec[pick_id];
            wdata_q <= wdata_vec[pick_id];
        end
        if (state == LO) begin
            rd_hi_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.ack       = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
`ifdef MEM_BOUNDS_CHECK_EN
                    state_nxt = oob ? DONE : HI;
`else
                    state_nxt = HI;
`endif
                end
            end
            HI: begin
                bus.mem_addr  = wrap_addr({1'b0, addr_q});
                bus.mem_wdata = wdata_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                bus.mem_we    = we_q;
                state_nxt     = LO;
            end
            LO: begin
                bus.mem_addr  = wrap_addr({1'b0, addr_q} + 17'd1);
                bus.mem_wdata = wdata_q[BYTE_WIDTH-1:0];
                bus.mem_we    = we_q;
                state_nxt     = TAIL;
            end
            TAIL: begin
                state_nxt = DONE;
            end
            DONE: begin
                bus.ack[grant_q] = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model with a byte memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DEPTH = MEM_DEPTH;
    localparam int AW    = $clog2(DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MEM_DEPTH(DEPTH), .WORD_WIDTH(WORD_WIDTH)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    // Byte memory: registered read returning the pre-write contents.
    logic [7:0]    mem [DEPTH];
    logic          fill_en   = 1'b0;
    logic          poke_en   = 1'b0;
    logic [15:0]   poke_addr = '0;
    logic [7:0]    poke_data = '0;

    function automatic logic [7:0] fill_pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    always @(posedge clock) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= fill_pat(i);
        end else if (poke_en) begin
            mem[poke_addr[AW-1:0]] <= poke_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[AW-1:0]];
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clock);
        poke_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.req = '0;
        nreset  = 1'b0;
        repeat (2) @(negedge clock);
        nreset  = 1'b1;
    endtask

    task automatic set_lane(input int id, input bit w, input logic [15:0] a, input logic [15:0] d);
        bus.req[id]             = 1'b1;
        bus.we[id]              = w;
        bus.addr_in[16*id +: 16]  = a;
        bus.wdata_in[16*id +: 16] = d;
    endtask

    // Single request; returns negedges from issue to ack (-1 on timeout).
    task automatic run_txn(input int id, input bit w, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic e,
                           output logic [2:0] ackv);
        lat  = -1;
        rd   = '0;
        e    = 1'b0;
        ackv = '0;
        @(negedge clock);
        bus.req = '0;
        set_lane(id, w, a, d);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus.ack != 3'b000) begin
                lat  = k;
                ackv = bus.ack;
                rd   = bus.rdata;
                e    = bus.err;
                bus.req = '0;
                break;
            end
        end
        bus.req = '0;
    endtask

    typedef struct {
        int          id;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        bit          pre;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int id, input bit w, input logic [15:0] a, input logic [15:0] d,
                                input bit pre, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [15:0] exp_rd, input bit exp_err, input int exp_lat);
        vec_t v;
        v.id = id; v.w = w; v.a = a; v.d = d; v.pre = pre; v.b0 = b0; v.b1 = b1;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    logic [7:0] ref_mem [DEPTH];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        e;
        logic [2:0]  ackv;

        bus.req = '0; bus.we = '0; bus.addr_in = '0; bus.wdata_in = '0;

        // Hold-off in reset: every output at its reset value.
        repeat (3) @(negedge clock);
        check("rst_ack",      32'(bus.ack), 32'(0));
        check("rst_rdata",    32'(bus.rdata), 32'(0));
        check("rst_err",      32'(bus.err), 32'(0));
        check("rst_mem_we",   32'(bus.mem_we), 32'(0));
        check("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        nreset = 1'b1;

        tbl.push_back(mk(0, 0, BATTERY_BASE, 16'h0000, 1, 8'hAB, 8'hCD, 16'hABCD, 0, 4));
        tbl.push_back(mk(1, 0, ACTION_BASE,  16'h0000, 1, 8'h01, 8'h02, 16'h0102, 0, 4));
        tbl.push_back(mk(2, 1, QVALUE_BASE,  16'h1234, 1, 8'h55, 8'h66, 16'h5566, 0, 4));
        tbl.push_back(mk(0, 0, QVALUE_BASE,  16'h0000, 0, 8'h00, 8'h00, 16'h1234, 0, 4));
        tbl.push_back(mk(1, 0, 16'h03FE,     16'h0000, 1, 8'h9A, 8'hBC, 16'h9ABC, 0, 4));
        tbl.push_back(mk(2, 0, 16'h03FF,     16'h0000, 1, 8'hEE, 8'h11,
                         BC ? 16'h0000 : 16'hEE11, BC, BC ? 1 : 4));
        tbl.push_back(mk(0, 1, 16'h0010,     16'hBEEF, 1, 8'h00, 8'h00, 16'h0000, 0, 4));
        tbl.push_back(mk(1, 0, 16'h0010,     16'h0000, 0, 8'h00, 8'h00, 16'hBEEF, 0, 4));

        foreach (tbl[i]) begin
            if (tbl[i].pre) begin
                poke(tbl[i].a, tbl[i].b0);
                poke(tbl[i].a + 16'd1, tbl[i].b1);
            end
            run_txn(tbl[i].id, tbl[i].w, tbl[i].a, tbl[i].d, lat, rd, e, ackv);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("tbl%0d_ack", i), 32'(ackv), 32'(1) << tbl[i].id);
            check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end

        // All three requesting after reset: rotation 0,1,2 with 5-cycle spacing.
        begin
            logic [2:0] got_ack [3];
            int         got_k [3];
            int         n = 0;
            do_reset();
            @(negedge clock);
            set_lane(0, 0, ACTION_BASE, 16'h0);
            set_lane(1, 0, BATTERY_BASE, 16'h0);
            set_lane(2, 0, QVALUE_BASE, 16'h0);
            for (int k = 1; k <= 30 && n < 3; k++) begin
                @(negedge clock);
                if (bus.ack != 3'b000) begin
                    got_ack[n] = bus.ack;
                    got_k[n]   = k;
                    bus.req    = bus.req & ~bus.ack;
                    n++;
                end
            end
            bus.req = '0;
            check("rr_count", 32'(n), 32'(3));
            for (int i = 0; i < n; i++) begin
                check($sformatf("rr_ack%0d", i), 32'(got_ack[i]), 32'(1) << i);
                check($sformatf("rr_cycle%0d", i), 32'(got_k[i]), 32'(4 + 5 * i));
            end
        end

        // Write strobes: two high cycles, high byte at base then low byte at base+1.
        begin
            int          nwe = 0;
            logic [15:0] wa [2];
            logic [7:0]  wd [2];
            int          ack_k = -1;
            @(negedge clock);
            bus.req = '0;
            set_lane(2, 1, QVALUE_BASE, 16'h1234);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clock);
                if (bus.mem_we) begin
                    if (nwe < 2) begin
                        wa[nwe] = bus.mem_addr;
                        wd[nwe] = bus.mem_wdata;
                    end
                    nwe++;
                end
                if (bus.ack == 3'b100 && ack_k < 0) begin
                    ack_k   = k;
                    bus.req = '0;
                end
            end
            bus.req = '0;
            check("wr_we_cycles", 32'(nwe), 32'(2));
            if (nwe >= 2) begin
                check("wr_addr_hi", 32'(wa[0]), 32'(QVALUE_BASE));
                check("wr_data_hi", 32'(wd[0]), 32'h12);
                check("wr_addr_lo", 32'(wa[1]), 32'(QVALUE_BASE + 16'd1));
                check("wr_data_lo", 32'(wd[1]), 32'h34);
            end
            check("wr_ack_cycle", 32'(ack_k), 32'(4));
        end

        // Reset during LO: aborts at once; rotation restarts at requester 0.
        begin
            int         ack_k = -1;
            logic [2:0] first_ack = '0;
            run_txn(0, 0, ACTION_BASE, 16'h0, lat, rd, e, ackv);
            @(negedge clock);
            bus.req = '0;
            set_lane(0, 0, ACTION_BASE, 16'h0);
            set_lane(1, 1, 16'h0020, 16'hA5A5);
            repeat (2) @(negedge clock);
            check("abort_lo_we", 32'(bus.mem_we), 32'(1));
            #1 nreset = 1'b0;
            #1;
            check("abort_mem_we",   32'(bus.mem_we), 32'(0));
            check("abort_mem_addr", 32'(bus.mem_addr), 32'(0));
            check("abort_ack",      32'(bus.ack), 32'(0));
            check("abort_rdata",    32'(bus.rdata), 32'(0));
            @(negedge clock);
            nreset = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clock);
                if (bus.ack != 3'b000) begin
                    ack_k     = k;
                    first_ack = bus.ack;
                    break;
                end
            end
            bus.req = '0;
            check("abort_next_grant", 32'(first_ack), 32'(3'b001));
            check("abort_next_cycle", 32'(ack_k), 32'(4));
        end

        // Request withdrawn during HI still completes with a single ack.
        begin
            int nack = 0;
            int ack_k = -1;
            logic [2:0] av = '0;
            repeat (2) @(negedge clock);
            bus.req = '0;
            set_lane(1, 0, BATTERY_BASE, 16'h0);
            @(negedge clock);
            bus.req[1] = 1'b0;
            for (int k = 2; k <= 12; k++) begin
                @(negedge clock);
                if (bus.ack != 3'b000) begin
                    nack++;
                    ack_k = k;
                    av    = bus.ack;
                end
            end
            check("drop_ack_count", 32'(nack), 32'(1));
            check("drop_ack_cycle", 32'(ack_k), 32'(4));
            check("drop_ack_id",    32'(av), 32'(3'b010));
        end

        // Randomized traffic against the transaction-level model.
        begin
            bit          pend [3];
            bit          rq_we [3];
            logic [15:0] rq_a [3];
            logic [15:0] rq_d [3];
            int          m_last = 2;
            int          due = -1;
            int          exp_id = 0;
            logic [15:0] exp_rd = '0;
            bit          exp_err = 1'b0;
            localparam int NCYC = 3000;

            @(negedge clock);
            fill_en = 1'b1;
            @(negedge clock);
            fill_en = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill_pat(i);
            for (int i = 0; i < 3; i++) begin
                pend[i] = 1'b0; rq_we[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0;
            end
            do_reset();

            for (int k = 0; k < NCYC; k++) begin
                logic [2:0] exp_ack;
                logic [2:0] seen;
                @(negedge clock);
                exp_ack = (k == due) ? 3'(1 << exp_id) : 3'b000;
                seen    = bus.ack;
                check($sformatf("rnd_ack@%0d", k), 32'(seen), 32'(exp_ack));
                if (k == due) begin
                    check($sformatf("rnd_rdata@%0d", k), 32'(bus.rdata), 32'(exp_rd));
                    check($sformatf("rnd_err@%0d", k), 32'(bus.err), 32'(exp_err));
                end
                for (int i = 0; i < 3; i++) begin
                    if (seen[i]) begin
                        pend[i] = 1'b0;
                    end else if (!pend[i] && k < NCYC - 40 && $urandom_range(0, 3) == 0) begin
                        pend[i]  = 1'b1;
                        rq_we[i] = 1'($urandom_range(0, 1));
                        rq_d[i]  = 16'($urandom);
                        case ($urandom_range(0, 3))
                            0:       rq_a[i] = 16'($urandom_range(DEPTH - 3, DEPTH - 1));
                            1:       rq_a[i] = ACTION_BASE + 16'($urandom_range(0, 255));
                            2:       rq_a[i] = 16'($urandom_range(0, DEPTH - 1));
                            default: rq_a[i] = 16'($urandom);
                        endcase
                    end
                end
                bus.req = '0;
                for (int i = 0; i < 3; i++) begin
                    if (pend[i]) set_lane(i, rq_we[i], rq_a[i], rq_d[i]);
                end

                // Arbiter is free again the cycle after its previous ack.
                if (k > due) begin
                    for (int j = 1; j <= 3; j++) begin
                        int c;
                        c = (m_last + j) % 3;
                        if (pend[c]) begin
                            logic [AW-1:0] ra;
                            logic [AW-1:0] rb;
                            ra     = rq_a[c][AW-1:0];
                            rb     = ra + 1'b1;
                            exp_id = c;
                            m_last = c;
                            if (BC && int'(rq_a[c]) > DEPTH - 2) begin
                                exp_rd  = '0;
                                exp_err = 1'b1;
                                due     = k + 1;
                            end else begin
                                exp_rd  = {ref_mem[ra], ref_mem[rb]};
                                exp_err = 1'b0;
                                due     = k + 4;
                                if (rq_we[c]) begin
                                    ref_mem[ra] = rq_d[c][15:8];
                                    ref_mem[rb] = rq_d[c][7:0];
                                end
                            end
                            break;
                        end
                    end
                end
            end
            bus.req = '0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
